// File: rtl/riscv_core_fetchalign.sv
// riscv_core_fetchalign
//   Fetch-alignment buffer between instruction memory and decode. Takes
//   32-bit word-aligned fetch words and presents one whole instruction per
//   handshake (16-bit RVC parcel or 32-bit instruction, possibly straddling
//   two fetch words) together with its PC. Owns the sequential fetch PC and
//   handles flush redirects to 2-byte-aligned targets.
//
// Ports
//   i_fetchalign_clk        clock, rising edge
//   i_fetchalign_rstn       asynchronous active-low reset
//   i_fetchalign_word       fetch word, [15:0] is the lower-address halfword
//   i_fetchalign_valid      fetch word valid
//   o_fetchalign_ready      buffer accepts the word this cycle
//   i_fetchalign_flush      redirect, highest priority
//   i_fetchalign_flushpc    redirect target (bit 0 ignored)
//   o_fetchalign_instr      instruction ({16'h0, parcel} when compressed)
//   o_fetchalign_pc         PC of o_fetchalign_instr
//   o_fetchalign_compressed instruction is 16-bit
//   o_fetchalign_valid      instruction valid
//   i_fetchalign_ready      decode accepts the instruction
module riscv_core_fetchalign #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        i_fetchalign_clk,
  input  logic        i_fetchalign_rstn,
  input  logic [31:0] i_fetchalign_word,
  input  logic        i_fetchalign_valid,
  output logic        o_fetchalign_ready,
  input  logic        i_fetchalign_flush,
  input  logic [63:0] i_fetchalign_flushpc,
  output logic [31:0] o_fetchalign_instr,
  output logic [63:0] o_fetchalign_pc,
  output logic        o_fetchalign_compressed,
  output logic        o_fetchalign_valid,
  input  logic        i_fetchalign_ready
);

  // hw_q[0] is the oldest halfword; entries at index >= count_q are stale.
  logic [15:0] hw_q [3];
  logic [15:0] hw_d [3];
  logic [1:0]  count_q, count_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_low_q, drop_low_d;

  logic        head_comp;
  logic [1:0]  size;
  logic [1:0]  rem;
  logic        out_fire;
  logic        in_fire;
  logic [15:0] first_hw;

  // Redirect targets are halfword aligned; the byte offset bit is discarded.
  logic unused_flushpc_lsb;
  assign unused_flushpc_lsb = i_fetchalign_flushpc[0];

  always_comb begin
    head_comp = (hw_q[0][1:0] != 2'b11);
    size      = head_comp ? 2'd1 : 2'd2;

    o_fetchalign_valid      = !i_fetchalign_flush && (count_q >= size);
    o_fetchalign_instr      = head_comp ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
    o_fetchalign_pc         = pc_q;
    o_fetchalign_compressed = head_comp;

    out_fire = o_fetchalign_valid && i_fetchalign_ready;
    // Occupancy left after this cycle's consume; ready looks through the
    // consume so a full buffer can still stream at one word per cycle.
    rem      = count_q - (out_fire ? size : 2'd0);
    o_fetchalign_ready = !i_fetchalign_flush && (rem <= 2'd1);
    in_fire  = i_fetchalign_valid && o_fetchalign_ready;

    // After a misaligned redirect the low halfword of the first word precedes
    // the target and is skipped.
    first_hw = drop_low_q ? i_fetchalign_word[31:16] : i_fetchalign_word[15:0];

    for (int unsigned i = 0; i < 3; i++) begin
      hw_d[i] = hw_q[i];
    end
    count_d    = count_q;
    pc_d       = pc_q;
    drop_low_d = drop_low_q;

    if (i_fetchalign_flush) begin
      count_d    = 2'd0;
      pc_d       = {i_fetchalign_flushpc[63:1], 1'b0};
      drop_low_d = i_fetchalign_flushpc[1];
    end else begin
      if (out_fire) begin
        pc_d = pc_q + (head_comp ? 64'd2 : 64'd4);
        if (head_comp) begin
          hw_d[0] = hw_q[1];
          hw_d[1] = hw_q[2];
        end else begin
          hw_d[0] = hw_q[2];
        end
      end
      count_d = rem;
      if (in_fire) begin
        // rem is 0 or 1 whenever in_fire is set.
        if (rem[0]) begin
          hw_d[1] = first_hw;
          if (!drop_low_q) hw_d[2] = i_fetchalign_word[31:16];
        end else begin
          hw_d[0] = first_hw;
          if (!drop_low_q) hw_d[1] = i_fetchalign_word[31:16];
        end
        count_d    = rem + (drop_low_q ? 2'd1 : 2'd2);
        drop_low_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_fetchalign_clk or negedge i_fetchalign_rstn) begin
    if (!i_fetchalign_rstn) begin
      for (int unsigned i = 0; i < 3; i++) begin
        hw_q[i] <= '0;
      end
      count_q    <= '0;
      pc_q       <= {RESET_PC[63:1], 1'b0};
      drop_low_q <= RESET_PC[1];
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        hw_q[i] <= hw_d[i];
      end
      count_q    <= count_d;
      pc_q       <= pc_d;
      drop_low_q <= drop_low_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_fetchalign.sv
module tb_riscv_core_fetchalign;

  logic        clk;
  logic        rstn;
  logic [31:0] word;
  logic        ivalid;
  logic        oready;
  logic        flush;
  logic [63:0] flushpc;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        comp;
  logic        ovalid;
  logic        iready;

  int errors = 0;
  int checks = 0;

  riscv_core_fetchalign #(.RESET_PC(64'h0)) dut (
    .i_fetchalign_clk        (clk),
    .i_fetchalign_rstn       (rstn),
    .i_fetchalign_word       (word),
    .i_fetchalign_valid      (ivalid),
    .o_fetchalign_ready      (oready),
    .i_fetchalign_flush      (flush),
    .i_fetchalign_flushpc    (flushpc),
    .o_fetchalign_instr      (instr),
    .o_fetchalign_pc         (pc),
    .o_fetchalign_compressed (comp),
    .o_fetchalign_valid      (ovalid),
    .i_fetchalign_ready      (iready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_instr,
                         input logic [63:0] e_pc, input logic e_comp);
    chk({tag, ".valid"}, 64'(ovalid), 64'd1);
    chk({tag, ".instr"}, 64'(instr), 64'(e_instr));
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".comp"}, 64'(comp), 64'(e_comp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One flush cycle; decode and fetch handshakes must both be blocked.
  task automatic do_flush(input string tag, input logic [63:0] target);
    flush   = 1'b1;
    flushpc = target;
    #1;
    chk({tag, ".flush_ovalid"}, 64'(ovalid), 64'd0);
    chk({tag, ".flush_oready"}, 64'(oready), 64'd0);
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] stream_word(input int k);
    return 32'h00100093 + (32'(k) << 20);
  endfunction

  initial begin
    rstn = 1'b0; word = '0; ivalid = 1'b0; flush = 1'b0; flushpc = '0; iready = 1'b1;
    tick();
    tick();
    chk("reset.ovalid", 64'(ovalid), 64'd0);
    chk("reset.oready", 64'(oready), 64'd1);
    rstn = 1'b1;

    // 32-bit instruction after reset
    word = 32'h00500093; ivalid = 1'b1;
    #1;
    chk("t1.oready", 64'(oready), 64'd1);
    chk("t1.empty", 64'(ovalid), 64'd0);
    tick();
    ivalid = 1'b0;
    chk_out("t1", 32'h00500093, 64'h0, 1'b0);
    tick();
    chk("t1.drained", 64'(ovalid), 64'd0);

    // Compressed pair
    do_flush("t2", 64'h0);
    word = {16'h4505, 16'h0505}; ivalid = 1'b1;
    #1;
    chk("t2.oready0", 64'(oready), 64'd1);
    tick();
    ivalid = 1'b0;
    chk_out("t2a", 32'h00000505, 64'h0, 1'b1);
    chk("t2.oready1", 64'(oready), 64'd1);
    tick();
    chk_out("t2b", 32'h00004505, 64'h2, 1'b1);
    chk("t2.oready2", 64'(oready), 64'd1);
    tick();
    chk("t2.drained", 64'(ovalid), 64'd0);

    // Straddling 32-bit instruction
    do_flush("t3", 64'h0);
    word = {16'h0093, 16'h0505}; ivalid = 1'b1;
    tick();
    word = {16'h4505, 16'h0050};
    #1;
    chk_out("t3a", 32'h00000505, 64'h0, 1'b1);
    chk("t3.oready", 64'(oready), 64'd1);
    tick();
    ivalid = 1'b0;
    chk_out("t3b", 32'h00500093, 64'h2, 1'b0);
    tick();
    chk_out("t3c", 32'h00004505, 64'h6, 1'b1);
    tick();
    chk("t3.drained", 64'(ovalid), 64'd0);

    // Misaligned redirect drops the low halfword of the first word
    do_flush("t4", 64'h102);
    word = {16'h0505, 16'hFFFF}; ivalid = 1'b1;
    #1;
    chk("t4.oready", 64'(oready), 64'd1);
    tick();
    ivalid = 1'b0;
    chk_out("t4a", 32'h00000505, 64'h102, 1'b1);
    tick();
    chk("t4.only_one", 64'(ovalid), 64'd0);
    word = 32'h00500093; ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    chk_out("t4b", 32'h00500093, 64'h104, 1'b0);
    tick();

    // Backpressure: decode stalls for 5 cycles
    do_flush("t5", 64'h0);
    iready = 1'b0;
    word = stream_word(0); ivalid = 1'b1;
    #1;
    chk("t5.accept0", 64'(oready), 64'd1);
    tick();
    for (int c = 0; c < 4; c++) begin
      word = stream_word(1);
      #1;
      chk_out("t5.stall", stream_word(0), 64'h0, 1'b0);
      chk("t5.stall_oready", 64'(oready), 64'd0);
      tick();
    end
    iready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      word = stream_word(k + 1);
      #1;
      chk_out("t5.stream", stream_word(k), 64'(4 * k), 1'b0);
      chk("t5.stream_oready", 64'(oready), 64'd1);
      tick();
    end
    ivalid = 1'b0;
    #1;
    chk_out("t5.last", stream_word(5), 64'd20, 1'b0);
    tick();
    chk("t5.drained", 64'(ovalid), 64'd0);

    // Flush collides with fetch and decode handshakes
    iready = 1'b0;
    word = {16'h4505, 16'h0505}; ivalid = 1'b1;
    tick();
    chk_out("t6.head", 32'h00000505, 64'd24, 1'b1);
    word = 32'h00500093; iready = 1'b1;
    do_flush("t6", 64'h200);
    ivalid = 1'b0;
    #1;
    chk("t6.not_accepted", 64'(ovalid), 64'd0);
    word = 32'h00500093; ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    chk_out("t6.after", 32'h00500093, 64'h200, 1'b0);
    tick();

    // Asynchronous reset with three halfwords buffered
    iready = 1'b0;
    word = {16'h0093, 16'h0505}; ivalid = 1'b1;
    tick();
    word = {16'h4505, 16'h0050}; iready = 1'b1;
    tick();
    ivalid = 1'b0; iready = 1'b0;
    #1;
    chk_out("t7.full", 32'h00500093, 64'h206, 1'b0);
    chk("t7.full_oready", 64'(oready), 64'd0);
    #1;
    rstn = 1'b0;
    #1;
    chk("t7.async_ovalid", 64'(ovalid), 64'd0);
    chk("t7.async_oready", 64'(oready), 64'd1);
    tick();
    rstn = 1'b1;
    #1;
    chk("t7.post_reset", 64'(ovalid), 64'd0);
    word = {16'h4505, 16'h0505}; ivalid = 1'b1; iready = 1'b1;
    tick();
    ivalid = 1'b0;
    chk_out("t7.restart", 32'h00000505, 64'h0, 1'b1);
    tick();
    chk_out("t7.restart2", 32'h00004505, 64'h2, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_fetchalign.md
# riscv_core_fetchalign

Fetch-alignment buffer between instruction memory and the decode stage. It accepts 32-bit, word-aligned fetch words and emits one complete instruction per handshake with its PC: 16-bit compressed (RVC) parcels or 32-bit instructions, including 32-bit instructions that straddle two fetch words. Decode, and from it the immediate extender, only ever see whole, correctly aligned instructions. It owns the sequential fetch PC, redirects on flush, and handles 2-byte-aligned redirect targets.

## Interface
- RESET_PC, 64'h0: PC of the first instruction after reset; bit 0 is ignored and bit 1 is honoured.
- i_fetchalign_clk  in  1  clock; all state updates on the rising edge.
- i_fetchalign_rstn  in  1  asynchronous, active-low reset.
- i_fetchalign_word  in  32  fetch word; bits [15:0] are the lower-address halfword.
- i_fetchalign_valid  in  1  fetch word valid.
- o_fetchalign_ready  out  1  buffer can take the word this cycle.
- i_fetchalign_flush  in  1  redirect; highest priority.
- i_fetchalign_flushpc  in  64  redirect target; bit 0 is ignored.
- o_fetchalign_instr  out  32  instruction; a compressed instruction is presented as {16'h0, parcel}.
- o_fetchalign_pc  out  64  PC of o_fetchalign_instr.
- o_fetchalign_compressed  out  1  instruction is 16-bit.
- o_fetchalign_valid  out  1  instruction valid.
- i_fetchalign_ready  in  1  decode accepts the instruction.

## Operation
- **State**
  - Halfword buffer hw[0..2], where hw[0] is the oldest.
  - count, range 0..3.
  - Head PC register pc.
  - drop_low flag.
- **Head decode**
  - Head is compressed iff hw[0][1:0] != 2'b11.
  - size = 1 halfword if compressed, else 2.
- **Output**
  - o_valid = !flush && (count >= size).
  - instr = compressed ? {16'h0, hw[0]} : {hw[1], hw[0]}.
  - o_pc = pc; o_compressed = head compressed.
  - When o_valid = 0, instr, pc and compressed are don't-care. The bench checks them only while valid.
- **Consume** (out_fire = o_valid && i_ready)
  - Buffer shifts down by size.
  - pc += 2 × size (2 or 4), modulo 2^64.
- **Accept**
  - rem = count − (out_fire ? size : 0).
  - o_ready = !flush && (rem <= 1). This is combinational on i_fetchalign_ready, which allows full-rate streaming.
  - in_fire = i_valid && o_ready.
  - Normal accept: both halfwords are written at hw[rem], hw[rem+1], and count = rem + 2.
  - If drop_low = 1: only word[31:16] is written at hw[rem], count = rem + 1, and drop_low clears.
- **Flush**
  - count = 0, pc = {flushpc[63:1], 1'b0}, drop_low = flushpc[1].
  - In the flush cycle no in_fire and no out_fire occur; upstream re-fetches the word at flushpc & ~3.
- **Simultaneous events**
  - Consume and accept in the same cycle are both applied, using the rem computation above.
  - Flush overrides both.
- **Capacity**
  - count never exceeds 3.
  - With count = 3, o_ready = 1 only when out_fire consumes 2 halfwords.
- **Reset** (asynchronous, any time, including mid-stream)
  - count = 0, pc = RESET_PC with bit 0 cleared, drop_low = RESET_PC[1].
  - Outputs after reset: o_valid = 0, o_ready = 1.
  - Partially buffered parcels are discarded.

## Timing
- Latency: a word accepted at edge N makes its first instruction valid in the cycle after edge N. There is no combinational path from i_word to o_instr.
- Throughput: one instruction per cycle for any mix of 16/32-bit instructions, provided fetch words arrive every cycle with i_valid = 1.
- While o_valid = 1 and i_ready = 0, instr, pc and compressed stay stable until out_fire or flush.
- The first valid instruction after a flush appears no earlier than the cycle after the first post-flush in_fire.
- A straddling 32-bit instruction (upper halfword of word k plus lower halfword of word k+1) becomes valid the cycle after word k+1 is accepted.

## Test plan
- **32-bit instruction after reset**
  - Stimulus: RESET_PC = 0; reset, then word 32'h00500093.
  - Required: next cycle, valid with instr 32'h00500093, pc 0, compressed 0.
- **Compressed pair**
  - Stimulus: word {16'h4505, 16'h0505}.
  - Required: two outputs in consecutive cycles: 32'h00000505 at pc 0 and 32'h00004505 at pc 2, both compressed 1. o_ready = 1 throughout.
- **Straddle**
  - Stimulus: word {16'h0093, 16'h0505}, then word {16'h4505, 16'h0050}.
  - Required:
    - 32'h0505 at pc 0;
    - 32'h00500093 at pc 2 (compressed 0);
    - 32'h4505 at pc 6.
- **Misaligned flush**
  - Stimulus: flush with flushpc 64'h102, then word {16'h0505, 16'hFFFF}.
  - Required: lower halfword dropped; only 32'h0505 at pc 64'h102 is output, then pc becomes 64'h104.
  - Also required: in the flush cycle, o_valid = 0 and o_ready = 0.
- **Backpressure**
  - Stimulus: stream of 32-bit instructions; i_ready held 0 for 5 cycles.
  - Required: outputs held stable, o_ready = 0 once count = 2.
  - After release: one instruction per cycle, PCs incrementing by 4, with no loss or duplication against a reference model.
- **Collisions and reset**
  - Stimulus: flush asserted with i_valid = 1 and i_ready = 1.
  - Required: the word is not accepted and the head is not consumed.
  - Stimulus: rstn pulsed low mid-stream with count = 3.
  - Required: o_valid = 0 immediately (asynchronously); restart from RESET_PC.
